// File: rtl/mips_pkg.sv
// Shared core definitions: datapath width, default reset PC and the
// prefetch queue entry layout used by the fetch stage.
package mips_pkg;

    localparam int REG_WIDTH = 32;
    localparam logic [REG_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Queue entry: instruction word in the upper half, its PC+1 in the lower half
    typedef struct packed {
        logic [REG_WIDTH-1:0] instr;
        logic [REG_WIDTH-1:0] pc_plus_1;
    } fetch_entry_t;

    localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect request and the
// valid/ready decode handshake.
interface fetch_prefetch_unit_if
    import mips_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int DEPTH = 4
);

    logic [WIDTH-1:0]         imem_addr;
    logic [WIDTH-1:0]         imem_rdata;
    logic                     imem_ready;
    logic                     redirect_en;
    logic [WIDTH-1:0]         redirect_pc;
    logic                     dec_valid;
    logic                     dec_ready;
    logic [WIDTH-1:0]         dec_instr;
    logic [WIDTH-1:0]         dec_pc_plus_1;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        output imem_addr, dec_valid, dec_instr, dec_pc_plus_1, occupancy,
        input  imem_rdata, imem_ready, redirect_en, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_addr, dec_valid, dec_instr, dec_pc_plus_1, occupancy,
        output imem_rdata, imem_ready, redirect_en, redirect_pc, dec_ready
    );

endinterface

// File: rtl/prefetch_fifo.sv
// Prefetch queue: synchronous write, asynchronous head read, flushable.
// The caller guarantees push never targets a full queue unless it also pops.
module prefetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = ENTRY_WIDTH
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ENTRY_W-1:0]       wdata,
    output logic [ENTRY_W-1:0]       head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wptr_r;
    logic [PTR_W-1:0]   rptr_r;
    logic [PTR_W:0]     count_r;

    // Entry storage; contents are only meaningful below count_r, so no reset
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push/pop
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            count_r <= {(PTR_W+1){1'b0}};
        end else if (flush) begin
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            count_r <= {(PTR_W+1){1'b0}};
        end else begin
            if (push) begin
                wptr_r <= wptr_r + PTR_W'(1);
            end
            if (pop) begin
                rptr_r <= rptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = (count_r != {(PTR_W+1){1'b0}}) ? mem_r[rptr_r] : {ENTRY_W{1'b0}};
    assign count = count_r;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage with a prefetch queue towards decode; redirects
// flush the queue and restart fetch at the branch/jump target.
module fetch_prefetch_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH    = REG_WIDTH,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   arst_n,
    fetch_prefetch_unit_if.master  bus
);

    localparam int ENTRY_W = WIDTH * (ENTRY_WIDTH / REG_WIDTH);
    localparam int OCC_W   = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    logic [WIDTH-1:0]   pc_r;
    logic [WIDTH-1:0]   pc_plus_1_s;
    logic               fetch_s;
    logic               pop_s;
    logic               valid_s;
    logic [ENTRY_W-1:0] head_s;
    logic [OCC_W-1:0]   occupancy_s;

    // Fetch/pop decision; redirect suppresses fetch for the cycle it is seen
    always_comb begin
        pc_plus_1_s = pc_r + WIDTH'(1);
        valid_s     = (occupancy_s != {OCC_W{1'b0}});
        pop_s       = valid_s && bus.dec_ready;
        fetch_s     = bus.imem_ready && !bus.redirect_en &&
                      ((occupancy_s < DEPTH_C) || pop_s);
    end

    // Fetch PC register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc_r <= RESET_PC;
        end else if (bus.redirect_en) begin
            pc_r <= bus.redirect_pc;
        end else if (fetch_s) begin
            pc_r <= pc_plus_1_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    prefetch_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .flush  (bus.redirect_en),
        .push   (fetch_s),
        .pop    (pop_s),
        .wdata  ({bus.imem_rdata, pc_plus_1_s}),
        .head   (head_s),
        .count  (occupancy_s)
    );

    assign bus.imem_addr     = pc_r;
    assign bus.dec_valid     = valid_s;
    assign bus.dec_instr     = head_s[ENTRY_W-1:WIDTH];
    assign bus.dec_pc_plus_1 = head_s[WIDTH-1:0];
    assign bus.occupancy     = occupancy_s;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: streaming, back-pressure, redirect,
// imem stalls, PC wrap and asynchronous reset.
module tb_fetch_prefetch_unit;

    logic clk = 1'b0;
    logic arst_a_n = 1'b0;
    logic arst_b_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_prefetch_unit_if #(.WIDTH(32), .DEPTH(4)) bus_a ();
    fetch_prefetch_unit_if #(.WIDTH(32), .DEPTH(4)) bus_b ();

    assign bus_a.imem_rdata = 32'hA000_0000 + bus_a.imem_addr;
    assign bus_b.imem_rdata = 32'hA000_0000 + bus_b.imem_addr;

    fetch_prefetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
        .clk    (clk),
        .arst_n (arst_a_n),
        .bus    (bus_a)
    );

    fetch_prefetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFF)) dut_b (
        .clk    (clk),
        .arst_n (arst_b_n),
        .bus    (bus_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset_a();
        arst_a_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(bus_a.dec_valid), 32'd0);
        check_eq("rst_occ", 32'(bus_a.occupancy), 32'd0);
        check_eq("rst_addr", bus_a.imem_addr, 32'h0000_0000);
        arst_a_n = 1'b1;
    endtask

    initial begin
        bus_a.imem_ready  = 1'b1;
        bus_a.dec_ready   = 1'b1;
        bus_a.redirect_en = 1'b0;
        bus_a.redirect_pc = 32'h0000_0000;
        bus_b.imem_ready  = 1'b1;
        bus_b.dec_ready   = 1'b1;
        bus_b.redirect_en = 1'b0;
        bus_b.redirect_pc = 32'h0000_0000;

        #12;
        check_eq("reset_valid", 32'(bus_a.dec_valid), 32'd0);
        check_eq("reset_occ", 32'(bus_a.occupancy), 32'd0);
        check_eq("reset_instr", bus_a.dec_instr, 32'h0000_0000);
        check_eq("reset_pcp1", bus_a.dec_pc_plus_1, 32'h0000_0000);
        arst_a_n = 1'b1;
        check_eq("c0_addr", bus_a.imem_addr, 32'h0000_0000);

        // Streaming: one instruction per cycle from address 0
        for (int k = 1; k <= 4; k++) begin
            step();
            check_eq("stream_valid", 32'(bus_a.dec_valid), 32'd1);
            check_eq("stream_instr", bus_a.dec_instr, 32'hA000_0000 + 32'(k - 1));
            check_eq("stream_pcp1", bus_a.dec_pc_plus_1, 32'(k));
            check_eq("stream_occ", 32'(bus_a.occupancy), 32'd1);
        end

        // Fill under back-pressure, then drain while still fetching
        bus_a.dec_ready = 1'b0;
        pulse_reset_a();
        for (int k = 1; k <= 8; k++) begin
            step();
            check_eq("fill_occ", 32'(bus_a.occupancy), (k < 4) ? 32'(k) : 32'd4);
        end
        check_eq("fill_addr", bus_a.imem_addr, 32'h0000_0004);
        check_eq("fill_head", bus_a.dec_pc_plus_1, 32'h0000_0001);
        bus_a.dec_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_eq("full_pp_occ", 32'(bus_a.occupancy), 32'd4);
            check_eq("full_pp_pcp1", bus_a.dec_pc_plus_1, 32'(k + 1));
            check_eq("full_pp_instr", bus_a.dec_instr, 32'hA000_0000 + 32'(k));
        end

        // Redirect with three entries queued and a simultaneous pop
        bus_a.dec_ready = 1'b0;
        pulse_reset_a();
        step(); step(); step();
        check_eq("pre_redir_occ", 32'(bus_a.occupancy), 32'd3);
        bus_a.redirect_en = 1'b1;
        bus_a.redirect_pc = 32'h0000_0040;
        bus_a.dec_ready   = 1'b1;
        step();
        bus_a.redirect_en = 1'b0;
        check_eq("redir_occ", 32'(bus_a.occupancy), 32'd0);
        check_eq("redir_valid", 32'(bus_a.dec_valid), 32'd0);
        check_eq("redir_addr", bus_a.imem_addr, 32'h0000_0040);
        step();
        check_eq("redir_instr", bus_a.dec_instr, 32'hA000_0040);
        check_eq("redir_pcp1", bus_a.dec_pc_plus_1, 32'h0000_0041);
        check_eq("redir_occ1", 32'(bus_a.occupancy), 32'd1);

        // imem_ready toggling: bubbles on low cycles, PC holds
        bus_a.imem_ready = 1'b0;
        step();
        check_eq("imem0_valid", 32'(bus_a.dec_valid), 32'd0);
        check_eq("imem0_addr", bus_a.imem_addr, 32'h0000_0041);
        bus_a.imem_ready = 1'b1;
        step();
        check_eq("imem1_valid", 32'(bus_a.dec_valid), 32'd1);
        check_eq("imem1_instr", bus_a.dec_instr, 32'hA000_0041);
        check_eq("imem1_addr", bus_a.imem_addr, 32'h0000_0042);
        bus_a.imem_ready = 1'b0;
        step();
        check_eq("imem0b_valid", 32'(bus_a.dec_valid), 32'd0);
        check_eq("imem0b_addr", bus_a.imem_addr, 32'h0000_0042);
        bus_a.redirect_en = 1'b1;
        bus_a.redirect_pc = 32'h0000_0080;
        step();
        bus_a.redirect_en = 1'b0;
        bus_a.imem_ready  = 1'b1;
        check_eq("stall_redir_addr", bus_a.imem_addr, 32'h0000_0080);
        step();
        check_eq("stall_redir_instr", bus_a.dec_instr, 32'hA000_0080);
        check_eq("stall_redir_pcp1", bus_a.dec_pc_plus_1, 32'h0000_0081);

        // Back-to-back redirects: the last one wins
        bus_a.redirect_en = 1'b1;
        bus_a.redirect_pc = 32'h0000_0100;
        step();
        check_eq("rr1_addr", bus_a.imem_addr, 32'h0000_0100);
        check_eq("rr1_valid", 32'(bus_a.dec_valid), 32'd0);
        bus_a.redirect_pc = 32'h0000_0200;
        step();
        bus_a.redirect_en = 1'b0;
        check_eq("rr2_addr", bus_a.imem_addr, 32'h0000_0200);
        check_eq("rr2_occ", 32'(bus_a.occupancy), 32'd0);
        step();
        check_eq("rr2_instr", bus_a.dec_instr, 32'hA000_0200);
        check_eq("rr2_pcp1", bus_a.dec_pc_plus_1, 32'h0000_0201);

        // PC wrap from 0xFFFFFFFF and asynchronous reset mid-stream
        arst_b_n = 1'b1;
        check_eq("wrap_addr0", bus_b.imem_addr, 32'hFFFF_FFFF);
        step();
        check_eq("wrap_pcp1_0", bus_b.dec_pc_plus_1, 32'h0000_0000);
        check_eq("wrap_instr_0", bus_b.dec_instr, 32'h9FFF_FFFF);
        step();
        check_eq("wrap_pcp1_1", bus_b.dec_pc_plus_1, 32'h0000_0001);
        check_eq("wrap_instr_1", bus_b.dec_instr, 32'hA000_0000);
        #2;
        arst_b_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(bus_b.dec_valid), 32'd0);
        check_eq("arst_occ", 32'(bus_b.occupancy), 32'd0);
        check_eq("arst_addr", bus_b.imem_addr, 32'hFFFF_FFFF);
        arst_b_n = 1'b1;
        step();
        check_eq("restart_pcp1", bus_b.dec_pc_plus_1, 32'h0000_0000);
        check_eq("restart_valid", 32'(bus_b.dec_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
